serializador_aprovados: RTL
===========================

Name: serializador_aprovados

Overview:
Downstream stage of the active-node evaluator in the path-search engine. It takes a snapshot of the vector of approved active nodes and emits them one at a time, lowest index first, over a valid/ready handshake to the neighbour-expansion stage. For each emitted node it also writes the node's predecessor ("anterior") into the predecessor memory. When every node in the snapshot has been sent, it pulses the remove-approved request back to the evaluator and flags the destination node if that node was among those sent.

Parameters:
NUM_NA, 4, number of active-node slots in the evaluator
ADDR_WIDTH, 5, width of a node address
DISTANCIA_WIDTH, 5, width of a node distance

Ports:
clk  in  1  clock; everything is registered on its rising edge
rst  in  1  synchronous, active-high reset
aa_pronto_in  in  1  evaluator classification is complete
aa_aprovado_in  in  NUM_NA  approved flag per slot
aa_endereco_in  in  ADDR_WIDTH*NUM_NA  slot addresses, slot i at bits [ADDR_WIDTH*i +: ADDR_WIDTH]
aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  slot distances, packed the same way
aa_anterior_data_in  in  ADDR_WIDTH*NUM_NA  slot predecessors, packed the same way
destino_in  in  ADDR_WIDTH  destination node address
limpar_destino_in  in  1  clears the sticky destination flag
consumidor_pronto_in  in  1  downstream ready
sa_valido_out  out  1  node output is valid
sa_endereco_out  out  ADDR_WIDTH  address of the emitted node
sa_distancia_out  out  DISTANCIA_WIDTH  distance of the emitted node
mem_wr_en_out  out  1  predecessor-memory write strobe
mem_wr_addr_out  out  ADDR_WIDTH  write address (the node address)
mem_wr_data_out  out  ADDR_WIDTH  write data (the node's predecessor)
sa_remover_aprovados_out  out  1  one-cycle pulse: evaluator must clear its approved slots
sa_destino_encontrado_out  out  1  sticky: the destination node has been emitted
sa_ocupado_out  out  1  high whenever the FSM is not in OCIOSO

Behaviour:
- All outputs are registered. Under rst every output resets to 0, the pendente register is cleared and the FSM goes to OCIOSO.
- FSM states: OCIOSO, SELECIONA, ENVIA, REMOVER, ESPERA.
- OCIOSO:
  - Start condition: aa_pronto_in && |aa_aprovado_in.
  - On start, in the same edge: pendente <= aa_aprovado_in, and all three data buses are snapshotted into internal registers. Next state is SELECIONA.
  - Later changes on the inputs have no effect until the block returns to OCIOSO.
- SELECIONA:
  - If pendente == 0, go to REMOVER.
  - Otherwise take k = lowest set bit of pendente. Load sa_endereco_out, sa_distancia_out and an internal anterior register from snapshot slot k, set sa_valido_out <= 1, and go to ENVIA.
- ENVIA:
  - Outputs are held stable while consumidor_pronto_in is low; sa_valido_out is never withdrawn before the transfer.
  - Transfer (fire) occurs on a cycle where sa_valido_out && consumidor_pronto_in.
  - On fire:
    - sa_valido_out <= 0 and pendente[k] <= 0.
    - mem_wr_en_out <= 1 for exactly one cycle, with mem_wr_addr_out = node address and mem_wr_data_out = node predecessor.
    - If the node address == destino_in, sa_destino_encontrado_out <= 1.
    - Next state is SELECIONA.
  - Minimum throughput is one node per 2 cycles.
- REMOVER: sa_remover_aprovados_out = 1 for exactly one cycle, then go to ESPERA.
- ESPERA: stay until aa_aprovado_in == 0, then go to OCIOSO. This prevents re-capturing stale approved flags.
- Latency: the first sa_valido_out is asserted 2 cycles after the start edge. sa_remover_aprovados_out is asserted 2 cycles after the last fire.
- sa_destino_encontrado_out is cleared only by rst or limpar_destino_in. If limpar_destino_in and a destination match occur in the same cycle, the set wins.
- mem_wr_en_out defaults to 0 in every cycle that has no fire.
- A reset asserted mid-operation abandons the remaining nodes with no memory write and no remove pulse.

Decomposition:
- Shared package (constants header) holds:
  - FSM state encodings: OCIOSO=0, SELECIONA=1, ENVIA=2, REMOVER=3, ESPERA=4, in a 3-bit state register.
  - Default widths shared with the evaluator: NUM_NA, ADDR_WIDTH, DISTANCIA_WIDTH.
- One sub-module, codificador_prioridade (parameter NUM_NA):
  - Combinational lowest-set-bit encoder.
  - Outputs an index of width $clog2(NUM_NA) plus a flag that is high when any bit is set.

Test Plan:
1. aprovado=4'b1010; slot1 = (addr 3, dist 7, prev 2); slot3 = (addr 9, dist 4, prev 3); ready held at 1 -> emits addr 3 then addr 9. Writes are (3,2) then (9,3), each a one-cycle strobe. Remove pulse arrives 2 cycles after the second fire.
2. Same stimulus with ready=0 for 5 cycles -> sa_valido_out stays 1 with addr 3 stable throughout; no memory write until ready=1.
3. aprovado=4'b1111 and destino_in=9, with slot2 addr=9 -> four nodes emitted in order 0,1,2,3. sa_destino_encontrado_out rises on the third fire and stays 1 until limpar_destino_in.
4. aa_pronto_in=1 with aprovado=0 -> the block stays in OCIOSO: sa_ocupado_out=0 and no remove pulse.
5. After the remove pulse, aprovado held nonzero for 3 extra cycles -> the block stays in ESPERA and does not re-emit. When aprovado drops to 0 it returns to OCIOSO.
6. rst=1 while in ENVIA with 2 nodes still pending -> next cycle all outputs are 0 and the state is OCIOSO; no write and no remove pulse follow.

Source files
------------

// File: rtl/serializador_aprovados_pkg.sv
// Shared constants for the approved-node serializer: default widths used by the
// active-node evaluator and the serializer FSM state encoding.
package serializador_aprovados_pkg;

  localparam int NUM_NA          = 4;
  localparam int ADDR_WIDTH      = 5;
  localparam int DISTANCIA_WIDTH = 5;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    SELECIONA = 3'd1,
    ENVIA     = 3'd2,
    REMOVER   = 3'd3,
    ESPERA    = 3'd4
  } estado_t;

endpackage

// File: rtl/serializador_aprovados_if.sv
// Signal bundle between the evaluator, the serializer, the neighbour-expansion
// stage and the predecessor memory. master = serializer side.
interface serializador_aprovados_if
  import serializador_aprovados_pkg::*;
#(
  parameter int P_NUM_NA          = NUM_NA,
  parameter int P_ADDR_WIDTH      = ADDR_WIDTH,
  parameter int P_DISTANCIA_WIDTH = DISTANCIA_WIDTH
);
  logic                                      aa_pronto_in;
  logic [P_NUM_NA-1:0]                       aa_aprovado_in;
  logic [P_ADDR_WIDTH*P_NUM_NA-1:0]          aa_endereco_in;
  logic [P_DISTANCIA_WIDTH*P_NUM_NA-1:0]     aa_distancia_in;
  logic [P_ADDR_WIDTH*P_NUM_NA-1:0]          aa_anterior_data_in;
  logic [P_ADDR_WIDTH-1:0]                   destino_in;
  logic                                      limpar_destino_in;
  logic                                      consumidor_pronto_in;
  logic                                      sa_valido_out;
  logic [P_ADDR_WIDTH-1:0]                   sa_endereco_out;
  logic [P_DISTANCIA_WIDTH-1:0]              sa_distancia_out;
  logic                                      mem_wr_en_out;
  logic [P_ADDR_WIDTH-1:0]                   mem_wr_addr_out;
  logic [P_ADDR_WIDTH-1:0]                   mem_wr_data_out;
  logic                                      sa_remover_aprovados_out;
  logic                                      sa_destino_encontrado_out;
  logic                                      sa_ocupado_out;

  modport master (
    input  aa_pronto_in, aa_aprovado_in, aa_endereco_in, aa_distancia_in,
           aa_anterior_data_in, destino_in, limpar_destino_in, consumidor_pronto_in,
    output sa_valido_out, sa_endereco_out, sa_distancia_out, mem_wr_en_out,
           mem_wr_addr_out, mem_wr_data_out, sa_remover_aprovados_out,
           sa_destino_encontrado_out, sa_ocupado_out
  );

  modport slave (
    output aa_pronto_in, aa_aprovado_in, aa_endereco_in, aa_distancia_in,
           aa_anterior_data_in, destino_in, limpar_destino_in, consumidor_pronto_in,
    input  sa_valido_out, sa_endereco_out, sa_distancia_out, mem_wr_en_out,
           mem_wr_addr_out, mem_wr_data_out, sa_remover_aprovados_out,
           sa_destino_encontrado_out, sa_ocupado_out
  );

endinterface

// File: rtl/serializador_aprovados_codificador_prioridade.sv
// Lowest-set-bit priority encoder: o_indice is the lowest set position of i_bits,
// o_valido flags that at least one bit is set.
module codificador_prioridade #(
  parameter  int NUM_NA = 4,
  localparam int IDX_W  = (NUM_NA > 1) ? $clog2(NUM_NA) : 1
) (
  input  logic [NUM_NA-1:0] i_bits,
  output logic [IDX_W-1:0]  o_indice,
  output logic              o_valido
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_indice = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (i_bits[i]) o_indice = IDX_W'(i);
    end
  end

  assign o_valido = |i_bits;

endmodule

// File: rtl/serializador_aprovados.sv
// Snapshots the evaluator's approved slots and emits them lowest index first over
// valid/ready, logging each node's predecessor and pulsing remove when done.
module serializador_aprovados
  import serializador_aprovados_pkg::*;
#(
  parameter int P_NUM_NA          = NUM_NA,
  parameter int P_ADDR_WIDTH      = ADDR_WIDTH,
  parameter int P_DISTANCIA_WIDTH = DISTANCIA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  serializador_aprovados_if.master sa_bus
);

  localparam int IDX_W = (P_NUM_NA > 1) ? $clog2(P_NUM_NA) : 1;

  estado_t                              r_state, w_state_next;
  logic [P_NUM_NA-1:0]                  r_pendente, w_pendente_next;
  logic [IDX_W-1:0]                     r_idx, w_idx_next, w_idx;
  logic                                 w_algum;
  logic                                 w_capturar;
  logic [P_ADDR_WIDTH*P_NUM_NA-1:0]     r_end_snap, r_ant_snap;
  logic [P_DISTANCIA_WIDTH*P_NUM_NA-1:0] r_dist_snap;
  logic [P_ADDR_WIDTH-1:0]              w_end_slot  [P_NUM_NA];
  logic [P_ADDR_WIDTH-1:0]              w_ant_slot  [P_NUM_NA];
  logic [P_DISTANCIA_WIDTH-1:0]         w_dist_slot [P_NUM_NA];

  logic                         r_valido, w_valido_next;
  logic [P_ADDR_WIDTH-1:0]      r_endereco, w_endereco_next;
  logic [P_DISTANCIA_WIDTH-1:0] r_distancia, w_distancia_next;
  logic [P_ADDR_WIDTH-1:0]      r_anterior, w_anterior_next;
  logic                         r_mem_en, w_mem_en_next;
  logic [P_ADDR_WIDTH-1:0]      r_mem_addr, w_mem_addr_next;
  logic [P_ADDR_WIDTH-1:0]      r_mem_data, w_mem_data_next;
  logic                         r_remover, w_remover_next;
  logic                         r_destino, w_destino_next;
  logic                         r_ocupado;

  generate
    for (genvar gi = 0; gi < P_NUM_NA; gi++) begin : g_slot
      assign w_end_slot[gi]  = r_end_snap[P_ADDR_WIDTH*gi +: P_ADDR_WIDTH];
      assign w_ant_slot[gi]  = r_ant_snap[P_ADDR_WIDTH*gi +: P_ADDR_WIDTH];
      assign w_dist_slot[gi] = r_dist_snap[P_DISTANCIA_WIDTH*gi +: P_DISTANCIA_WIDTH];
    end
  endgenerate

  codificador_prioridade #(.NUM_NA(P_NUM_NA)) u_codificador (
    .i_bits   (r_pendente),
    .o_indice (w_idx),
    .o_valido (w_algum)
  );

  always_comb begin
    w_state_next     = r_state;
    w_pendente_next  = r_pendente;
    w_idx_next       = r_idx;
    w_capturar       = 1'b0;
    w_valido_next    = r_valido;
    w_endereco_next  = r_endereco;
    w_distancia_next = r_distancia;
    w_anterior_next  = r_anterior;
    w_mem_en_next    = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_data_next  = r_mem_data;
    w_remover_next   = 1'b0;
    w_destino_next   = r_destino & ~sa_bus.limpar_destino_in;
    case (r_state)
      OCIOSO: begin
        if (sa_bus.aa_pronto_in && |sa_bus.aa_aprovado_in) begin
          w_pendente_next = sa_bus.aa_aprovado_in;
          w_capturar      = 1'b1;
          w_state_next    = SELECIONA;
        end
      end
      SELECIONA: begin
        if (!w_algum) begin
          // Registered here so the pulse lines up exactly with the REMOVER cycle.
          w_remover_next = 1'b1;
          w_state_next   = REMOVER;
        end else begin
          w_idx_next       = w_idx;
          w_endereco_next  = w_end_slot[w_idx];
          w_distancia_next = w_dist_slot[w_idx];
          w_anterior_next  = w_ant_slot[w_idx];
          w_valido_next    = 1'b1;
          w_state_next     = ENVIA;
        end
      end
      ENVIA: begin
        if (r_valido && sa_bus.consumidor_pronto_in) begin
          w_valido_next          = 1'b0;
          w_pendente_next[r_idx] = 1'b0;
          w_mem_en_next          = 1'b1;
          w_mem_addr_next        = r_endereco;
          w_mem_data_next        = r_anterior;
          if (r_endereco == sa_bus.destino_in) w_destino_next = 1'b1;
          w_state_next = SELECIONA;
        end
      end
      REMOVER: w_state_next = ESPERA;
      ESPERA: begin
        // Wait for the evaluator to drop its flags so they are not captured twice.
        if (sa_bus.aa_aprovado_in == '0) w_state_next = OCIOSO;
      end
      default: w_state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= OCIOSO;
      r_pendente  <= '0;
      r_idx       <= '0;
      r_valido    <= 1'b0;
      r_endereco  <= '0;
      r_distancia <= '0;
      r_anterior  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_remover   <= 1'b0;
      r_destino   <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pendente  <= w_pendente_next;
      r_idx       <= w_idx_next;
      r_valido    <= w_valido_next;
      r_endereco  <= w_endereco_next;
      r_distancia <= w_distancia_next;
      r_anterior  <= w_anterior_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_data  <= w_mem_data_next;
      r_remover   <= w_remover_next;
      r_destino   <= w_destino_next;
      r_ocupado   <= (w_state_next != OCIOSO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_end_snap  <= '0;
      r_ant_snap  <= '0;
      r_dist_snap <= '0;
    end else if (w_capturar) begin
      r_end_snap  <= sa_bus.aa_endereco_in;
      r_ant_snap  <= sa_bus.aa_anterior_data_in;
      r_dist_snap <= sa_bus.aa_distancia_in;
    end
  end

  assign sa_bus.sa_valido_out             = r_valido;
  assign sa_bus.sa_endereco_out           = r_endereco;
  assign sa_bus.sa_distancia_out          = r_distancia;
  assign sa_bus.mem_wr_en_out             = r_mem_en;
  assign sa_bus.mem_wr_addr_out           = r_mem_addr;
  assign sa_bus.mem_wr_data_out           = r_mem_data;
  assign sa_bus.sa_remover_aprovados_out  = r_remover;
  assign sa_bus.sa_destino_encontrado_out = r_destino;
  assign sa_bus.sa_ocupado_out            = r_ocupado;

endmodule
